// File: rtl/sc_psrandom_pkg.sv
// Shared types and helpers for the PSRANDOM generator.
//   state_e       : control FSM states (IDLE / BURST / FREERUN)
//   default_taps  : maximal-length Galois tap masks for widths 4..32
//   lfsr_step     : one right-shifting Galois LFSR step on a 32-bit container;
//                   callers zero-extend their value and truncate the result.
package sc_psrandom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST   = 2'd1,
    ST_FREERUN = 2'd2
  } state_e;

  // Tap n of the classic maximal-length table maps to bit n-1 of the mask.
  function automatic logic [31:0] default_taps(input int width);
    logic [31:0] t;
    case (width)
      4:  t = 32'h0000000C;  5:  t = 32'h00000014;  6:  t = 32'h00000030;
      7:  t = 32'h00000060;  8:  t = 32'h000000B8;  9:  t = 32'h00000110;
      10: t = 32'h00000240;  11: t = 32'h00000500;  12: t = 32'h00000829;
      13: t = 32'h0000100D;  14: t = 32'h00002015;  15: t = 32'h00006000;
      16: t = 32'h0000D008;  17: t = 32'h00012000;  18: t = 32'h00020400;
      19: t = 32'h00040023;  20: t = 32'h00090000;  21: t = 32'h00140000;
      22: t = 32'h00300000;  23: t = 32'h00420000;  24: t = 32'h00E10000;
      25: t = 32'h01200000;  26: t = 32'h02000023;  27: t = 32'h04000013;
      28: t = 32'h09000000;  29: t = 32'h14000000;  30: t = 32'h20000029;
      31: t = 32'h48000000;  32: t = 32'h80200003;
      default: t = 32'h00000000;
    endcase
    return t;
  endfunction

  // Shift right; when the bit falling out is 1, fold the tap mask back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                            input logic [31:0] taps);
    return (state >> 1) ^ (state[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/sc_lfsr_core.sv
// LFSR register with seed / step / hold control and a zero-lockup guard.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset (register -> 1)
//   seed_en_i     : load seed_i (0 is replaced by 1); has priority over step
//   step_en_i     : advance one Galois step
//   seed_i        : zero-extended seed
//   next_o        : value the register takes on a step (combinational)
//   seed_o        : value the register takes on a seed load (combinational)
module sc_lfsr_core
  import sc_psrandom_pkg::*;
#(
  parameter int                   DATAWIDTH = 8,
  parameter logic [DATAWIDTH-1:0] TAPS      = DATAWIDTH'(default_taps(DATAWIDTH))
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 seed_en_i,
  input  logic                 step_en_i,
  input  logic [DATAWIDTH-1:0] seed_i,
  output logic [DATAWIDTH-1:0] next_o,
  output logic [DATAWIDTH-1:0] seed_o
);

  logic [DATAWIDTH-1:0] lfsr_q;
  logic [DATAWIDTH-1:0] lfsr_d;

  // All-zero is a lockup state of a Galois LFSR, so a zero seed becomes 1.
  assign seed_o = (seed_i == '0) ? DATAWIDTH'(1) : seed_i;
  assign next_o = DATAWIDTH'(lfsr_step(32'(lfsr_q), 32'(TAPS)));

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_en_i)      lfsr_d = seed_o;
    else if (step_en_i) lfsr_d = next_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= DATAWIDTH'(1);
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/sc_psrandom_engine.sv
// Pseudo-random generator with seed load, N-step burst and free-run modes.
// Ports:
//   CLOCK_50      : system clock (rising edge)
//   RESET_InHigh  : asynchronous reset, active-high
//   load_InLow    : seed-load request (active-low, debounced), acts on falling edge
//   rand_InLow    : generate request (active-low, debounced), acts on falling edge
//   mode_In       : 0 burst / 1 free-run, sampled only on a rand falling edge
//   burst_InBUS   : steps per burst, 0 behaves as 1
//   seed_InBUS    : seed value, zero-extended
//   data_OutBUS   : registered current LFSR value
//   valid_Out     : one-cycle pulse on every data_OutBUS update
//   busy_Out      : high while the FSM is not IDLE (also serves as state visibility)
// Handshake: valid_Out is a qualifier-only strobe; there is no ready/backpressure,
// the consumer must capture data_OutBUS in the cycle valid_Out is high.
module sc_psrandom_engine
  import sc_psrandom_pkg::*;
#(
  parameter int                   DATAWIDTH  = 8,
  parameter int                   SEEDWIDTH  = 4,
  parameter logic [DATAWIDTH-1:0] TAPS       = DATAWIDTH'(default_taps(DATAWIDTH)),
  parameter int                   BURSTWIDTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InHigh,
  input  logic                  load_InLow,
  input  logic                  rand_InLow,
  input  logic                  mode_In,
  input  logic [BURSTWIDTH-1:0] burst_InBUS,
  input  logic [SEEDWIDTH-1:0]  seed_InBUS,
  output logic [DATAWIDTH-1:0]  data_OutBUS,
  output logic                  valid_Out,
  output logic                  busy_Out
);

  state_e                state_q;
  logic                  prev_load_q, prev_rand_q;
  logic [BURSTWIDTH-1:0] cnt_q;
  logic [DATAWIDTH-1:0]  data_q;
  logic                  valid_q;

  logic                  load_fall, rand_fall;
  logic                  seed_en, step_en;
  logic [DATAWIDTH-1:0]  lfsr_next, lfsr_seed;
  logic [BURSTWIDTH-1:0] burst_m1;

  assign load_fall = prev_load_q & ~load_InLow;
  assign rand_fall = prev_rand_q & ~rand_InLow;
  assign seed_en   = load_fall;
  // Remaining steps after the first one of a burst.
  assign burst_m1  = (burst_InBUS == '0) ? '0 : burst_InBUS - BURSTWIDTH'(1);

  // A load always wins; in FREERUN the stopping rand edge does not step.
  always_comb begin
    step_en = 1'b0;
    if (!load_fall) begin
      case (state_q)
        ST_IDLE:    step_en = rand_fall;
        ST_BURST:   step_en = 1'b1;
        ST_FREERUN: step_en = ~rand_fall;
        default:    step_en = 1'b0;
      endcase
    end
  end

  sc_lfsr_core #(
    .DATAWIDTH (DATAWIDTH),
    .TAPS      (TAPS)
  ) u_core (
    .clk_i     (CLOCK_50),
    .rst_i     (RESET_InHigh),
    .seed_en_i (seed_en),
    .step_en_i (step_en),
    .seed_i    (DATAWIDTH'(seed_InBUS)),
    .next_o    (lfsr_next),
    .seed_o    (lfsr_seed)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      state_q     <= ST_IDLE;
      prev_load_q <= 1'b1;
      prev_rand_q <= 1'b1;
      cnt_q       <= '0;
      data_q      <= DATAWIDTH'(1);
      valid_q     <= 1'b0;
    end else begin
      prev_load_q <= load_InLow;
      prev_rand_q <= rand_InLow;
      valid_q     <= seed_en | step_en;
      if (seed_en)      data_q <= lfsr_seed;
      else if (step_en) data_q <= lfsr_next;

      if (load_fall) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rand_fall) begin
              if (mode_In) begin
                state_q <= ST_FREERUN;
              end else begin
                cnt_q <= burst_m1;
                if (burst_m1 != '0) state_q <= ST_BURST;
              end
            end
          end
          ST_BURST: begin
            // The edge that consumes the last remaining count performs the final step.
            if (cnt_q <= BURSTWIDTH'(1)) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - BURSTWIDTH'(1);
            end
          end
          ST_FREERUN: begin
            if (rand_fall) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_OutBUS = data_q;
  assign valid_Out   = valid_q;
  assign busy_Out    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sc_psrandom_engine.sv
// Self-checking bench for sc_psrandom_engine (DATAWIDTH=8, TAPS=8'hB8).
module tb_sc_psrandom_engine;

  localparam int DW = 8;
  localparam int SW = 4;
  localparam int BW = 4;
  localparam logic [DW-1:0] TAPS = 8'hB8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          load_n, rand_n, mode;
  logic [BW-1:0] burst;
  logic [SW-1:0] seed;
  logic [DW-1:0] data;
  logic          valid, busy;

  sc_psrandom_engine #(
    .DATAWIDTH  (DW),
    .SEEDWIDTH  (SW),
    .TAPS       (TAPS),
    .BURSTWIDTH (BW)
  ) dut (
    .CLOCK_50     (clk),
    .RESET_InHigh (rst),
    .load_InLow   (load_n),
    .rand_InLow   (rand_n),
    .mode_In      (mode),
    .burst_InBUS  (burst),
    .seed_InBUS   (seed),
    .data_OutBUS  (data),
    .valid_Out    (valid),
    .busy_Out     (busy)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_lfsr;

  // Reference: the sequence is defined by repeated halving with the tap
  // polynomial added whenever an odd value is halved.
  function automatic logic [DW-1:0] ref_next(input logic [DW-1:0] x);
    int v;
    v = int'(x) / 2;
    if (x % 2 == 1) v = v ^ int'(TAPS);
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] ref_seed(input logic [SW-1:0] s);
    return (s == 0) ? DW'(1) : DW'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=%0h expected=no_output at %0t", data, $time);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(data), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic void push_steps(input int n);
    for (int i = 0; i < n; i++) begin
      ref_lfsr = ref_next(ref_lfsr);
      exp_q.push_back(ref_lfsr);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [SW-1:0] s);
    @(negedge clk);
    seed   = s;
    load_n = 1'b0;
    ref_lfsr = ref_seed(s);
    exp_q.push_back(ref_lfsr);
    @(negedge clk);
    load_n = 1'b1;
    check("load_busy", 32'(busy), 32'd0);
    idle(2);
  endtask

  // hold: cycles rand stays low (a held button must not retrigger)
  task automatic do_burst(input logic [BW-1:0] n, input int hold);
    int eff;
    eff = (n == 0) ? 1 : int'(n);
    @(negedge clk);
    mode   = 1'b0;
    burst  = n;
    rand_n = 1'b0;
    push_steps(eff);
    @(negedge clk);
    check("burst_busy_start", 32'(busy), (eff > 1) ? 32'd1 : 32'd0);
    mode  = 1'($urandom_range(0, 1));
    burst = BW'($urandom);
    repeat (hold - 1) @(negedge clk);
    rand_n = 1'b1;
    idle(eff + 2);
    check("burst_busy_end", 32'(busy), 32'd0);
  endtask

  // m >= 2 steps, then stop with a rand edge or abort with a load of s.
  task automatic do_freerun(input int m, input bit abort_load, input logic [SW-1:0] s);
    @(negedge clk);
    mode   = 1'b1;
    rand_n = 1'b0;
    push_steps(m);
    if (abort_load) begin
      ref_lfsr = ref_seed(s);
      exp_q.push_back(ref_lfsr);
    end
    @(negedge clk);
    rand_n = 1'b1;
    check("free_busy_start", 32'(busy), 32'd1);
    mode  = 1'($urandom_range(0, 1));
    burst = BW'($urandom);
    repeat (m - 1) @(negedge clk);
    if (abort_load) begin
      seed   = s;
      load_n = 1'b0;
    end else begin
      rand_n = 1'b0;
    end
    @(negedge clk);
    load_n = 1'b1;
    rand_n = 1'b1;
    check("free_busy_end", 32'(busy), 32'd0);
    idle(3);
  endtask

  // Load arrives while a burst of n is still running, after 'after' steps.
  task automatic do_burst_abort(input logic [BW-1:0] n, input int after, input logic [SW-1:0] s);
    @(negedge clk);
    mode   = 1'b0;
    burst  = n;
    rand_n = 1'b0;
    push_steps(after);
    ref_lfsr = ref_seed(s);
    exp_q.push_back(ref_lfsr);
    @(negedge clk);
    rand_n = 1'b1;
    repeat (after - 1) @(negedge clk);
    seed   = s;
    load_n = 1'b0;
    @(negedge clk);
    load_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    idle(int'(n) + 2);
  endtask

  task automatic do_load_and_rand(input logic [SW-1:0] s);
    @(negedge clk);
    seed   = s;
    mode   = 1'($urandom_range(0, 1));
    load_n = 1'b0;
    rand_n = 1'b0;
    ref_lfsr = ref_seed(s);
    exp_q.push_back(ref_lfsr);
    @(negedge clk);
    load_n = 1'b1;
    rand_n = 1'b1;
    check("both_busy", 32'(busy), 32'd0);
    idle(3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    int n, a;
    rst    = 1'b1;
    load_n = 1'b1;
    rand_n = 1'b1;
    mode   = 1'b0;
    burst  = '0;
    seed   = '0;
    ref_lfsr = DW'(1);
    #1;
    check("reset_data", 32'(data), 32'h01);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // 1. seed 1
    do_load(4'h1);
    // 2. 4-step burst: B8 5C 2E 17
    do_burst(4'd4, 1);
    check("burst4_last", 32'(data), 32'hB7 ^ 32'hA0);
    // 3. zero seed then full period
    do_load(4'h0);
    check("zero_seed", 32'(data), 32'h01);
    do_freerun(255, 1'b0, 4'h0);
    check("period_255", 32'(data), 32'h01);
    // 4. free-run aborted by load of A
    do_freerun(7, 1'b1, 4'hA);
    check("abort_seed", 32'(data), 32'h0A);
    // 5. simultaneous load and rand
    do_load_and_rand(4'h5);
    check("both_data", 32'(data), 32'h05);
    // burst of 0 behaves as one step; held rand does not retrigger
    do_burst(4'd0, 1);
    do_burst(4'd3, 9);
    do_burst(4'd15, 2);
    do_burst_abort(4'd9, 4, 4'h3);

    // 6. reset during an 8-step burst
    @(negedge clk);
    mode   = 1'b0;
    burst  = 4'd8;
    rand_n = 1'b0;
    push_steps(8);
    @(negedge clk);
    rand_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_data", 32'(data), 32'h01);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    ref_lfsr = DW'(1);
    repeat (2) begin
      @(negedge clk);
      check("inrst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    idle(2);
    do_burst(4'd3, 1);
    check("post_reset_burst", 32'(data), 32'h2E);

    // randomized mix
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: do_load(SW'($urandom));
        1: do_burst(BW'($urandom), $urandom_range(1, 4));
        2: do_freerun($urandom_range(2, 20), 1'b0, 4'h0);
        3: do_freerun($urandom_range(2, 20), 1'b1, SW'($urandom));
        4: begin
          n = $urandom_range(2, 15);
          a = $urandom_range(1, n - 1);
          do_burst_abort(BW'(n), a, SW'($urandom));
        end
        default: do_load_and_rand(SW'($urandom));
      endcase
    end

    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
